// File: rtl/lock_ctrl.sv
// Keypad password lock sequencer: code entry, check, fail/lockout and password change.
// Moore outputs from registered state; '#' at N gives CHECK at N+1 and the verdict at N+2.
module lock_ctrl #(
  parameter int unsigned                PW_LEN      = 4,
  parameter logic [4*PW_LEN-1:0]        DEFAULT_PW  = 16'h1234,
  parameter int unsigned                MAX_FAIL    = 3,
  parameter int unsigned                TIMEOUT_CYC = 500000000,
  parameter int unsigned                MSG_CYC     = 100000000,
  parameter int unsigned                LOCK_CYC    = 1000000000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  key_en,
  input  logic [3:0]            key_num,
  output logic [4*PW_LEN-1:0]   entry_buf,
  output logic [3:0]            entry_cnt,
  output logic [2:0]            state_o,
  output logic                  unlocked,
  output logic                  error,
  output logic                  alarm,
  output logic [2:0]            fail_cnt,
  output logic                  pw_saved
);
  localparam int W = 4 * PW_LEN;
  localparam logic [31:0] T_IDLE = 32'(TIMEOUT_CYC - 1);
  localparam logic [31:0] T_MSG  = 32'(MSG_CYC - 1);
  localparam logic [31:0] T_LOCK = 32'(LOCK_CYC - 1);
  localparam logic [3:0]  K_A = 4'hA, K_B = 4'hB, K_STAR = 4'hE, K_HASH = 4'hF;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0, S_ENTER = 3'd1, S_CHECK = 3'd2, S_OPEN = 3'd3,
    S_FAIL = 3'd4, S_LOCK  = 3'd5, S_SET   = 3'd6
  } state_t;

  state_t         state_q, state_d;
  logic [W-1:0]   buf_q, buf_d, pw_q, pw_d;
  logic [3:0]     cnt_q, cnt_d;
  logic [31:0]    timer_q, timer_d;
  logic [2:0]     fail_q, fail_d;
  logic           saved_q, saved_d;
  logic           is_dig, expired, full;
  logic [W+3:0]   shifted;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      buf_q   <= '0;
      cnt_q   <= '0;
      timer_q <= '0;
      fail_q  <= '0;
      pw_q    <= DEFAULT_PW;
      saved_q <= 1'b0;
    end else begin
      state_q <= state_d;
      buf_q   <= buf_d;
      cnt_q   <= cnt_d;
      timer_q <= timer_d;
      fail_q  <= fail_d;
      pw_q    <= pw_d;
      saved_q <= saved_d;
    end
  end

  assign is_dig  = key_num <= 4'd9;
  assign expired = timer_q == 32'd0;
  assign full    = cnt_q == 4'(PW_LEN);
  assign shifted = {buf_q, key_num};

  always_comb begin
    state_d = state_q;
    buf_d   = buf_q;
    cnt_d   = cnt_q;
    fail_d  = fail_q;
    pw_d    = pw_q;
    saved_d = 1'b0;
    timer_d = expired ? 32'd0 : timer_q - 32'd1;
    // Digits past PW_LEN are dropped but still count as activity for the timer.
    if (key_en && is_dig && !full && (state_q == S_IDLE || state_q == S_ENTER || state_q == S_SET)) begin
      buf_d = shifted[W-1:0];
      cnt_d = cnt_q + 4'd1;
    end
    case (state_q)
      S_IDLE: begin
        if (key_en && is_dig) begin
          state_d = S_ENTER;
          timer_d = T_IDLE;
        end
      end
      S_ENTER: begin
        if (key_en && is_dig) begin
          timer_d = T_IDLE;
        end else if (key_en && key_num == K_STAR) begin
          buf_d = '0; cnt_d = '0; state_d = S_IDLE;
        end else if (key_en && key_num == K_HASH) begin
          state_d = S_CHECK;
        end else if (expired) begin
          buf_d = '0; cnt_d = '0; state_d = S_IDLE;
        end
      end
      S_CHECK: begin
        buf_d = '0;
        cnt_d = '0;
        if (full && buf_q == pw_q) begin
          fail_d  = '0;
          state_d = S_OPEN;
          timer_d = T_IDLE;
        end else begin
          fail_d = fail_q + 3'd1;
          if (fail_q + 3'd1 == 3'(MAX_FAIL)) begin
            state_d = S_LOCK;
            timer_d = T_LOCK;
          end else begin
            state_d = S_FAIL;
            timer_d = T_MSG;
          end
        end
      end
      S_FAIL: if (expired) state_d = S_IDLE;
      S_LOCK: begin
        if (expired) begin
          fail_d  = '0;
          state_d = S_IDLE;
        end
      end
      S_OPEN: begin
        if (key_en && (key_num == K_B || key_num == K_HASH)) begin
          state_d = S_IDLE;
        end else if (key_en && key_num == K_A) begin
          buf_d = '0; cnt_d = '0; state_d = S_SET; timer_d = T_IDLE;
        end else if (expired) begin
          state_d = S_IDLE;
        end
      end
      S_SET: begin
        if (key_en && is_dig) begin
          timer_d = T_IDLE;
        end else if (key_en && key_num == K_HASH && full) begin
          pw_d = buf_q; saved_d = 1'b1;
          buf_d = '0; cnt_d = '0; state_d = S_OPEN; timer_d = T_IDLE;
        end else if (key_en && key_num == K_STAR) begin
          buf_d = '0; cnt_d = '0; timer_d = T_IDLE;
          if (cnt_q == 4'd0) state_d = S_OPEN;
        end else if (expired) begin
          buf_d = '0; cnt_d = '0; state_d = S_OPEN; timer_d = T_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign entry_buf = buf_q;
  assign entry_cnt = cnt_q;
  assign state_o   = state_q;
  assign unlocked  = (state_q == S_OPEN) || (state_q == S_SET);
  assign error     = state_q == S_FAIL;
  assign alarm     = state_q == S_LOCK;
  assign fail_cnt  = fail_q;
  assign pw_saved  = saved_q;
endmodule
